// File: rtl/instr_loader.sv
// Instruction-memory loader: reassembles 9-bit words from byte pairs on a
// valid/ready stream and writes them at sequential addresses while holding the core.
module instr_loader #(
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D:0]   len,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [8:0]   wr_data,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WRITE,
    S_DONE
  } state_e;

  state_e       state_q, state_d;
  logic [D:0]   words_left_q;
  logic [D-1:0] addr_q;
  logic [7:0]   lo_q;
  logic         hi0_q;
  logic         err_q;

  logic         start_ok;
  logic         xfer;
  logic [D:0]   len_sat;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign xfer     = in_valid && in_ready;
  // Any length with the top bit set is at least the full memory depth.
  assign len_sat  = len[D] ? {1'b1, {D{1'b0}}} : len;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned
    // (which would infer a latch).
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d = (len_sat == '0) ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        if (xfer) state_d = S_HI;
      end
      S_HI: begin
        if (xfer) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = (words_left_q == {{D{1'b0}}, 1'b1}) ? S_DONE : S_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    core_hold = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LO, S_HI: begin
        in_ready  = 1'b1;
        core_hold = 1'b1;
      end
      S_WRITE: begin
        wr_en     = 1'b1;
        core_hold = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_left_q <= '0;
      addr_q       <= '0;
      lo_q         <= '0;
      hi0_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (start_ok) begin
        words_left_q <= len_sat;
        addr_q       <= '0;
        err_q        <= 1'b0;
      end
      if ((state_q == S_LO) && xfer) begin
        lo_q <= in_data;
      end
      if ((state_q == S_HI) && xfer) begin
        hi0_q <= in_data[0];
        // Malformed high byte flags an error but the word is still written.
        if (|in_data[7:1]) err_q <= 1'b1;
      end
      if (state_q == S_WRITE) begin
        addr_q       <= addr_q + 1'b1;
        words_left_q <= words_left_q - 1'b1;
      end
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = {hi0_q, lo_q};
  assign err     = err_q;

endmodule
